issue_ctrl: RTL

//  Scoreboard issue controller between the decode stage and the execute stage.

---
 rtl/issue_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/issue_ctrl.sv
// Scoreboard issue controller: tracks pending register writes of in-flight
// instructions, stalls decode on RAW/counter-saturation, and sequences pipeline drains.
module issue_ctrl #(
  parameter int NREGS   = 32,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     id_valid_i,
  input  logic [$clog2(NREGS)-1:0] id_rs1_i,
  input  logic [$clog2(NREGS)-1:0] id_rs2_i,
  input  logic                     id_uses_rs1_i,
  input  logic                     id_uses_rs2_i,
  input  logic [$clog2(NREGS)-1:0] id_rd_i,
  input  logic                     id_writes_rd_i,
  input  logic                     ex_ready_i,
  input  logic                     wb_valid_i,
  input  logic [$clog2(NREGS)-1:0] wb_rd_i,
  input  logic                     drain_req_i,
  output logic                     id_ready_o,
  output logic                     issue_o,
  output logic                     ex_valid_o,
  output logic                     drained_o,
  output logic                     busy_o,
  output logic [STALL_W-1:0]       stall_cnt_o,
  output logic                     error_o
);

  localparam int RW = $clog2(NREGS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   pend_q [NREGS];
  logic [CNT_W-1:0]   pend_d [NREGS];
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               ex_valid_q, drained_q, busy_q, busy_d, error_q, error_d;
  logic               hazard, structural, inc_en, ret_en;

  // Hazards look only at the registered counters, so a same-cycle retire never unblocks.
  always_comb begin
    hazard = (id_uses_rs1_i && (id_rs1_i != '0) && (pend_q[id_rs1_i] != '0)) ||
             (id_uses_rs2_i && (id_rs2_i != '0) && (pend_q[id_rs2_i] != '0));
    structural = id_writes_rd_i && (id_rd_i != '0) && (pend_q[id_rd_i] == CNT_MAX);
    id_ready_o = (state_q == ST_RUN) && ex_ready_i && !hazard && !structural;
    issue_o    = id_valid_i && id_ready_o;
  end

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pend_d  = pend_q;
    error_d = error_q;
    busy_d  = 1'b0;
    inc_en  = issue_o && id_writes_rd_i && (id_rd_i != '0);
    ret_en  = wb_valid_i && (wb_rd_i != '0);
    if (ret_en && (pend_q[wb_rd_i] == '0)) error_d = 1'b1;
    for (int i = 1; i < NREGS; i++) begin
      logic inc_i, dec_i;
      inc_i = inc_en && (id_rd_i == RW'(i));
      dec_i = ret_en && (wb_rd_i == RW'(i)) && (pend_q[i] != '0);
      if (inc_i && !dec_i)      pend_d[i] = pend_q[i] + CNT_W'(1);
      else if (dec_i && !inc_i) pend_d[i] = pend_q[i] - CNT_W'(1);
      busy_d = busy_d | (pend_d[i] != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (drain_req_i) state_d = ST_DRAIN;
      // busy_q is the OR of the registered counters, giving at least one DRAIN cycle.
      ST_DRAIN: if (!busy_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    stall_d = stall_q;
    if (id_valid_i && !id_ready_o && (stall_q != '1)) stall_d = stall_q + STALL_W'(1);
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_RUN;
      for (int i = 0; i < NREGS; i++) pend_q[i] <= '0;
      stall_q    <= '0;
      ex_valid_q <= 1'b0;
      drained_q  <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      state_q    <= state_d;
      pend_q     <= pend_d;
      stall_q    <= stall_d;
      ex_valid_q <= issue_o;
      drained_q  <= (state_d == ST_DONE);
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign ex_valid_o  = ex_valid_q;
  assign drained_o   = drained_q;
  assign busy_o      = busy_q;
  assign stall_cnt_o = stall_q;
  assign error_o     = error_q;

endmodule
